// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : ALU-op decode and operand select feeding a two-entry skid buffer
//            (valid/ready) toward the execute stage. Optional feature macro:
//            ALU_ISSUE_ILLEGAL_EN adds the out_illegal port.
// Revision : 1.0
// ============================================================================
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic                     Funct7b5,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
`ifdef ALU_ISSUE_ILLEGAL_EN
    output logic                     out_illegal,
`endif
    output logic [OPCODE_LENGTH-1:0] Operation
);

    localparam logic [OPCODE_LENGTH-1:0] c_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] c_SUB = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] c_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] c_OR  = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] c_XOR = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] c_SLL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] c_SRL = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] c_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] c_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] c_SLT = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] c_BAD = OPCODE_LENGTH'(4'b1111);

    logic [OPCODE_LENGTH-1:0] w_op;
    logic [DATA_WIDTH-1:0]    w_srcb;
    logic                     w_accept;
    logic                     w_consume;
    logic                     w_skid_valid_nxt;

    logic                     r_main_valid;
    logic [DATA_WIDTH-1:0]    r_main_a;
    logic [DATA_WIDTH-1:0]    r_main_b;
    logic [OPCODE_LENGTH-1:0] r_main_op;
    logic                     r_skid_valid;
    logic [DATA_WIDTH-1:0]    r_skid_a;
    logic [DATA_WIDTH-1:0]    r_skid_b;
    logic [OPCODE_LENGTH-1:0] r_skid_op;
    logic                     r_in_ready;

    always_comb begin
        w_op = c_BAD;
        case (ALUOp)
            2'b00: w_op = c_ADD;
            2'b01: begin
                case (Funct3)
                    3'b000, 3'b001: w_op = c_EQ;
                    3'b100:         w_op = c_SLT;
                    default:        w_op = c_BAD;
                endcase
            end
            default: begin
                // R-type and I-type share a table; only R-type honours SUB
                case (Funct3)
                    3'b000:  w_op = (ALUOp == 2'b10 && Funct7b5) ? c_SUB : c_ADD;
                    3'b001:  w_op = c_SLL;
                    3'b010:  w_op = c_SLT;
                    3'b100:  w_op = c_XOR;
                    3'b101:  w_op = Funct7b5 ? c_SRA : c_SRL;
                    3'b110:  w_op = c_OR;
                    3'b111:  w_op = c_AND;
                    default: w_op = c_BAD;
                endcase
            end
        endcase
    end

    assign w_srcb    = ALUSrc ? Imm : RD2;
    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_main_valid && out_ready;

    // in_ready is only ever low while skid holds data, so an accept never
    // coincides with a valid skid entry.
    assign w_skid_valid_nxt = !w_consume && (r_skid_valid || (w_accept && r_main_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_a     <= '0;
            r_main_b     <= '0;
            r_main_op    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_op    <= '0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_consume) begin
                if (r_skid_valid) begin
                    r_main_a  <= r_skid_a;
                    r_main_b  <= r_skid_b;
                    r_main_op <= r_skid_op;
                end else if (w_accept) begin
                    r_main_a  <= RD1;
                    r_main_b  <= w_srcb;
                    r_main_op <= w_op;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_main_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_a     <= RD1;
                    r_main_b     <= w_srcb;
                    r_main_op    <= w_op;
                end else begin
                    r_skid_a  <= RD1;
                    r_skid_b  <= w_srcb;
                    r_skid_op <= w_op;
                end
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign SrcA      = r_main_a;
    assign SrcB      = r_main_b;
    assign Operation = r_main_op;

`ifdef ALU_ISSUE_ILLEGAL_EN
    // 1111 is never a legal code, so the stored opcode fully identifies illegality
    assign out_illegal = (r_main_op == c_BAD);
`endif

endmodule
`default_nettype wire
